// File: rtl/spin_pkg.sv
// Shared types and default sizes for the spin-array anneal controller.
package spin_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSample,
        StHold
    } state_t;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefSpins = 32;
    localparam int unsigned DefCntW  = 16;

endpackage

// File: rtl/spin_anneal_schedule.sv
// Step/stage counters and the saturating, stage-wise decaying increment.
module spin_anneal_schedule
    import spin_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] num_stages,
    input  logic [CNT_W-1:0] steps_per_stage,
    input  logic [WIDTH-1:0] inc_init,
    input  logic [WIDTH-1:0] inc_decay,
    output logic             last_step,
    output logic             stage_done,
    output logic             no_stages,
    output logic [WIDTH-1:0] inc_next
);

    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] stages_q, stages_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] decay_q, decay_d;
    logic [WIDTH-1:0] cur_inc_q, cur_inc_d;

    always_comb begin
        steps_d   = steps_q;
        stages_d  = stages_q;
        step_d    = step_q;
        stage_d   = stage_q;
        decay_d   = decay_q;
        cur_inc_d = cur_inc_q;

        last_step  = (step_q == steps_q - CNT_W'(1));
        // stage_done marks the final step of the final stage
        stage_done = last_step && (stage_q == stages_q - CNT_W'(1));
        no_stages  = (stages_q == '0);

        if (load) begin
            steps_d   = (steps_per_stage == '0) ? CNT_W'(1) : steps_per_stage;
            stages_d  = num_stages;
            decay_d   = inc_decay;
            cur_inc_d = inc_init;
            step_d    = '0;
            stage_d   = '0;
        end else if (enable) begin
            if (last_step) begin
                step_d    = '0;
                stage_d   = stage_q + CNT_W'(1);
                cur_inc_d = (cur_inc_q > decay_q) ? (cur_inc_q - decay_q) : '0;
            end else begin
                step_d = step_q + CNT_W'(1);
            end
        end

        inc_next = cur_inc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            steps_q   <= CNT_W'(1);
            stages_q  <= '0;
            step_q    <= '0;
            stage_q   <= '0;
            decay_q   <= '0;
            cur_inc_q <= '0;
        end else begin
            steps_q   <= steps_d;
            stages_q  <= stages_d;
            step_q    <= step_d;
            stage_q   <= stage_d;
            decay_q   <= decay_d;
            cur_inc_q <= cur_inc_d;
        end
    end

endmodule

// File: rtl/spin_anneal_ctrl.sv
// Anneal sequencer: clear, stepped decaying increment, sign sample, valid/ready hand-off.
// Optional SPIN_ANNEAL_ABORT_EN adds an abort input that cuts CLEAR/RUN short to SAMPLE.
module spin_anneal_ctrl
    import spin_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned SPINS = DefSpins,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef SPIN_ANNEAL_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [CNT_W-1:0]       num_stages,
    input  logic [CNT_W-1:0]       steps_per_stage,
    input  logic [WIDTH-1:0]       inc_init,
    input  logic [WIDTH-1:0]       inc_decay,
    input  logic [SPINS*WIDTH-1:0] spin_value,
    output logic                   sys_rst,
    output logic [WIDTH-1:0]       increment,
    output logic                   busy,
    output logic [SPINS-1:0]       result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   done
);

    state_t state_q, state_d;

    logic             load, enable;
    logic             last_step, stage_done, no_stages;
    logic [WIDTH-1:0] inc_next;
    logic             abort_req;
    logic [SPINS-1:0] msbs;

    logic [WIDTH-1:0] increment_q;
    logic             busy_q;
    logic [SPINS-1:0] result_q;
    logic             result_valid_q;

`ifdef SPIN_ANNEAL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    spin_anneal_schedule #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_schedule (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .enable         (enable),
        .num_stages     (num_stages),
        .steps_per_stage(steps_per_stage),
        .inc_init       (inc_init),
        .inc_decay      (inc_decay),
        .last_step      (last_step),
        .stage_done     (stage_done),
        .no_stages      (no_stages),
        .inc_next       (inc_next)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        enable  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = (abort_req || no_stages) ? StSample : StRun;
            end
            StRun: begin
                enable = 1'b1;
                if (abort_req || stage_done) begin
                    state_d = StSample;
                end
            end
            StSample: state_d = StHold;
            StHold: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        msbs = '0;
        for (int s = 0; s < int'(SPINS); s++) begin
            msbs[s] = spin_value[s*WIDTH + WIDTH - 1];
        end
    end

    // Registered outputs are loaded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            increment_q    <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            increment_q    <= (state_d == StRun) ? inc_next : '0;
            busy_q         <= (state_d != StIdle);
            result_valid_q <= (state_d == StHold);
            if (state_q == StSample) begin
                result_q <= msbs;
            end
        end
    end

    assign sys_rst      = rst | (state_q == StClear);
    assign done         = (state_q == StHold) && result_ready;
    assign increment    = increment_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_spin_anneal_ctrl.sv
// Randomized self-checking bench for spin_anneal_ctrl against a schedule-level model.
module tb_spin_anneal_ctrl;

    localparam int WIDTH = 32;
    localparam int SPINS = 32;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   abort;
    logic [CNT_W-1:0]       num_stages;
    logic [CNT_W-1:0]       steps_per_stage;
    logic [WIDTH-1:0]       inc_init;
    logic [WIDTH-1:0]       inc_decay;
    logic [SPINS*WIDTH-1:0] spin_value;
    logic                   sys_rst;
    logic [WIDTH-1:0]       increment;
    logic                   busy;
    logic [SPINS-1:0]       result;
    logic                   result_valid;
    logic                   result_ready;
    logic                   done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spin_anneal_ctrl #(
        .WIDTH(WIDTH),
        .SPINS(SPINS),
        .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef SPIN_ANNEAL_ABORT_EN
        .abort          (abort),
`endif
        .num_stages     (num_stages),
        .steps_per_stage(steps_per_stage),
        .inc_init       (inc_init),
        .inc_decay      (inc_decay),
        .spin_value     (spin_value),
        .sys_rst        (sys_rst),
        .increment      (increment),
        .busy           (busy),
        .result         (result),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .done           (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stage k increment: inc_init - k*inc_decay, floored at zero.
    function automatic logic [31:0] model_inc(input logic [31:0] init, input logic [31:0] decay,
                                              input int k);
        longint unsigned sub;
        sub = longint'(decay) * longint'(k);
        return (sub >= longint'(init)) ? 32'd0 : 32'(longint'(init) - sub);
    endfunction

    function automatic logic [SPINS*WIDTH-1:0] gen_spins(input bit pat_en, input logic [31:0] pat);
        logic [SPINS*WIDTH-1:0] v;
        for (int s = 0; s < SPINS; s++) begin
            v[s*WIDTH +: WIDTH] = $urandom;
            if (pat_en) v[s*WIDTH + WIDTH - 1] = pat[s];
        end
        return v;
    endfunction

    function automatic logic [31:0] sign_bits(input logic [SPINS*WIDTH-1:0] v);
        logic [31:0] r;
        for (int s = 0; s < SPINS; s++) r[s] = v[s*WIDTH + WIDTH - 1];
        return r;
    endfunction

    task automatic scramble_cfg();
        num_stages      = CNT_W'($urandom);
        steps_per_stage = CNT_W'($urandom);
        inc_init        = $urandom;
        inc_decay       = $urandom;
    endtask

    // Caller is #1 after a posedge with the DUT idle; this cycle is cycle 0.
    task automatic run_sched(input int n, input int s, input logic [31:0] init,
                             input logic [31:0] decay, input int ready_dly,
                             input bit pat_en, input logic [31:0] pat);
        int s_eff;
        int total;
        logic [31:0] exp_inc[$];
        logic [31:0] exp_res;
        logic [SPINS*WIDTH-1:0] sv;
        s_eff = (s == 0) ? 1 : s;
        total = s_eff * n;
        exp_inc = {};
        exp_res = '0;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < s_eff; j++) exp_inc.push_back(model_inc(init, decay, k));

        num_stages      = CNT_W'(n);
        steps_per_stage = CNT_W'(s);
        inc_init        = init;
        inc_decay       = decay;
        start           = 1'b1;
        result_ready    = 1'b0;
        spin_value      = gen_spins(1'b0, 32'd0);
        @(posedge clk); #1;

        for (int c = 1; c <= total + 2; c++) begin
            if (c == 1) begin
                check("clear_sys_rst", sys_rst, 1);
                check("clear_busy", busy, 1);
                check("clear_inc", increment, 0);
            end else if (c <= total + 1) begin
                check("run_inc", increment, exp_inc[c-2]);
                check("run_sys_rst", sys_rst, 0);
            end else begin
                check("sample_inc", increment, 0);
                check("sample_valid", result_valid, 0);
            end
            // Config and start must be ignored once the run is under way.
            start = ($urandom_range(0, 3) == 0);
            scramble_cfg();
            result_ready = $urandom_range(0, 1);
            sv = gen_spins(pat_en && (c == total + 2), pat);
            spin_value = sv;
            if (c == total + 2) exp_res = sign_bits(sv);
            @(posedge clk); #1;
        end

        for (int d = 0; d <= ready_dly; d++) begin
            result_ready = (d == ready_dly);
            start        = (d == ready_dly);
            spin_value   = gen_spins(1'b0, 32'd0);
            #1;
            check("hold_valid", result_valid, 1);
            check("hold_result", result, exp_res);
            check("hold_inc", increment, 0);
            check("hold_done", done, result_ready);
            @(posedge clk); #1;
        end
        result_ready = 1'b0;
        start        = 1'b0;
        #1;
        check("post_busy", busy, 0);
        check("post_valid", result_valid, 0);
        check("post_done", done, 0);
        check("post_inc", increment, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        result_ready = 1'b0;
        spin_value = '0;
        scramble_cfg();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sys_rst", sys_rst, 1);
        check("rst_inc", increment, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_sys_rst", sys_rst, 0);

        run_sched(3, 4, 32'd100, 32'd30, 0, 1'b0, 32'd0);
        run_sched(3, 1, 32'd50, 32'd40, 1, 1'b0, 32'd0);
        run_sched(0, 2, 32'd77, 32'd5, 0, 1'b0, 32'd0);
        run_sched(2, 0, 32'd9, 32'd3, 0, 1'b0, 32'd0);
        run_sched(2, 3, 32'hFFFF_FFF0, 32'h8000_0000, 5, 1'b1, 32'hA5A5_A5A5);

        // Reset during RUN stage 1 (S=4: stage 1 starts at cycle 6).
        num_stages = 3; steps_per_stage = 4; inc_init = 100; inc_decay = 30;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("midrun_inc", increment, 70);
        rst = 1'b1;
        #1;
        check("midrun_sys_rst", sys_rst, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("after_rst_busy", busy, 0);
        check("after_rst_inc", increment, 0);
        check("after_rst_valid", result_valid, 0);
        check("after_rst_sys_rst", sys_rst, 0);
        run_sched(3, 4, 32'd100, 32'd30, 2, 1'b0, 32'd0);

`ifdef SPIN_ANNEAL_ABORT_EN
        begin
            logic [31:0] exp_abort;
            num_stages = 3; steps_per_stage = 4; inc_init = 100; inc_decay = 30;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 1; c < 7; c++) begin @(posedge clk); #1; end
            // RUN cycle 5 is cycle 7 of the run.
            check("abort_pre_inc", increment, 70);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            spin_value = gen_spins(1'b0, 32'd0);
            exp_abort = sign_bits(spin_value);
            check("abort_sample_inc", increment, 0);
            check("abort_sample_valid", result_valid, 0);
            @(posedge clk); #1;
            check("abort_valid", result_valid, 1);
            check("abort_result", result, exp_abort);
            result_ready = 1'b1;
            @(posedge clk); #1;
            result_ready = 1'b0;
            check("abort_idle", busy, 0);
        end
`endif

        for (int r = 0; r < 8; r++) begin
            logic [31:0] ri, rd;
            ri = $urandom;
            rd = ($urandom_range(0, 1) == 1) ? $urandom : ri >> $urandom_range(1, 3);
            run_sched($urandom_range(0, 4), $urandom_range(0, 5), ri, rd,
                      $urandom_range(0, 3), 1'b0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
